// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - two-requester round-robin Wishbone bus master with timeout
//
// Purpose:
//   Arbitrates between requester 0 (core data port) and requester 1 (DMA) and runs
//   one Wishbone classic transfer at a time. Each transfer passes through
//   IDLE -> BUS -> DONE, so there are at least three cycles per transfer and at
//   least one idle cycle between transfers. A transfer that sees no ack_i for
//   TIMEOUT bus cycles completes with an error and zero read data.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   mX_req_i                       transfer request, held until mX_ready_o
//   mX_addr_i, mX_wdata_i, mX_we_i transfer address, write data, direction
//   mX_ready_o, mX_err_o           one-cycle completion pulse, timeout flag
//   mX_rdata_o                     read data (shared register), valid with ready
//   cyc_o, stb_o, we_o             Wishbone master control
//   addr_o, data_o, sel_o          Wishbone address, write data, slave select
//   data_i, ack_i                  Wishbone slave read data and acknowledge

module wishbone_arbiter #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned SEL_LSB = 28
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m0_we_i,
    output logic        m0_ready_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic        m1_we_i,
    output logic        m1_ready_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,

    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [1:0]  sel_o,
    input  logic [31:0] data_i,
    input  logic        ack_i
);

    // Counter only has to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             grant;       // 0 = requester 0, 1 = requester 1
    logic             last_grant;  // requester served by the previous transfer
    logic             err;
    logic [CNT_W-1:0] count;

    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic [31:0]      rdata_q;
    logic             bus_q;       // registered cyc/stb
    logic [1:0]       ready_q;     // one-hot completion pulse per requester

    // Round-robin winner: a lone request wins outright, a tie goes to the
    // requester that was not served last.
    logic win;
    always_comb begin
        win = 1'b0;
        if (m0_req_i && m1_req_i) begin
            win = ~last_grant;
        end else begin
            win = m1_req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            err        <= 1'b0;
            count      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            bus_q      <= 1'b0;
            ready_q    <= 2'b00;
        end else begin
            ready_q <= 2'b00;
            case (state)
                IDLE: begin
                    // Requests are only looked at here; anything that changes
                    // during BUS or DONE waits for the next IDLE evaluation.
                    if (m0_req_i || m1_req_i) begin
                        grant   <= win;
                        addr_q  <= win ? m1_addr_i  : m0_addr_i;
                        wdata_q <= win ? m1_wdata_i : m0_wdata_i;
                        we_q    <= win ? m1_we_i    : m0_we_i;
                        count   <= '0;
                        bus_q   <= 1'b1;
                        state   <= BUS;
                    end
                end

                BUS: begin
                    if (ack_i) begin
                        // Writes leave the read-data register untouched.
                        if (!we_q) begin
                            rdata_q <= data_i;
                        end
                        err     <= 1'b0;
                        count   <= '0;
                        bus_q   <= 1'b0;
                        ready_q <= grant ? 2'b10 : 2'b01;
                        state   <= DONE;
                    end else if (count == CNT_LAST) begin
                        err     <= 1'b1;
                        rdata_q <= '0;
                        count   <= '0;
                        bus_q   <= 1'b0;
                        ready_q <= grant ? 2'b10 : 2'b01;
                        state   <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                DONE: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    bus_q <= 1'b0;
                end
            endcase
        end
    end

    assign cyc_o  = bus_q;
    assign stb_o  = bus_q;
    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = wdata_q;
    assign sel_o  = addr_q[SEL_LSB+1:SEL_LSB];

    assign m0_ready_o = ready_q[0];
    assign m1_ready_o = ready_q[1];
    assign m0_err_o   = ready_q[0] & err;
    assign m1_err_o   = ready_q[1] & err;
    assign m0_rdata_o = rdata_q;
    assign m1_rdata_o = rdata_q;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb/tb_wishbone_arbiter.sv - self-checking bench for wishbone_arbiter

module tb_wishbone_arbiter;

    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned SEL_LSB = 28;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] addr_o, data_o;
    logic [1:0]  sel_o;
    logic [31:0] data_i = 32'h0;
    logic        ack_i = 1'b0;

    always #5 clk = ~clk;

    wishbone_arbiter #(.TIMEOUT(TIMEOUT), .SEL_LSB(SEL_LSB)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_we_i(m0_we_i),
        .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_we_i(m1_we_i),
        .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
        .sel_o(sel_o), .data_i(data_i), .ack_i(ack_i)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // ---------------- transaction-level model ----------------
    bit          m_active = 1'b0;   // a transfer is on the bus this cycle
    bit          m_pulse = 1'b0;    // completion cycle
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    bit          m_err = 1'b0;
    bit          m_we = 1'b0;
    int          m_beats = 0;       // bus beats already spent without ack
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    wire         m_win = (m0_req_i && m1_req_i) ? !m_last : m1_req_i;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_active <= 0; m_pulse <= 0; m_last <= 1; m_err <= 0; m_we <= 0;
            m_beats <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_owner <= 0;
        end else if (m_pulse) begin
            m_pulse <= 0;
            m_last  <= m_owner;
        end else if (m_active) begin
            m_beats <= m_beats + 1;
            if (ack_i) begin
                m_active <= 0; m_pulse <= 1; m_err <= 0;
                if (!m_we) m_rdata <= data_i;
            end else if (m_beats + 1 == TIMEOUT) begin
                m_active <= 0; m_pulse <= 1; m_err <= 1; m_rdata <= '0;
            end
        end else if (m0_req_i || m1_req_i) begin
            m_owner  <= m_win;
            m_addr   <= m_win ? m1_addr_i : m0_addr_i;
            m_wdata  <= m_win ? m1_wdata_i : m0_wdata_i;
            m_we     <= m_win ? m1_we_i : m0_we_i;
            m_active <= 1;
            m_beats  <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_o", 32'(cyc_o), 32'(m_active));
            chk("stb_o", 32'(stb_o), 32'(m_active));
            chk("we_o", 32'(we_o), 32'(m_we));
            chk("addr_o", addr_o, m_addr);
            chk("data_o", data_o, m_wdata);
            chk("sel_o", 32'(sel_o), 32'(m_addr[SEL_LSB+:2]));
            chk("m0_ready_o", 32'(m0_ready_o), 32'(m_pulse && !m_owner));
            chk("m1_ready_o", 32'(m1_ready_o), 32'(m_pulse && m_owner));
            chk("m0_err_o", 32'(m0_err_o), 32'(m_pulse && !m_owner && m_err));
            chk("m1_err_o", 32'(m1_err_o), 32'(m_pulse && m_owner && m_err));
            chk("m0_rdata_o", m0_rdata_o, m_rdata);
            chk("m1_rdata_o", m1_rdata_o, m_rdata);
        end
    end

    // ---------------- requesters ----------------
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic we; } txn_t;
    txn_t q0[$];
    txn_t q1[$];
    int raise0 = 0;

    initial begin
        m0_req_i = 0; m0_addr_i = '0; m0_wdata_i = '0; m0_we_i = 0;
        forever begin
            @(negedge clk);
            if (m0_req_i && m0_ready_o && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                if (!m0_req_i) raise0 = cyc_n;
                m0_req_i = 1; m0_addr_i = q0[0].addr; m0_wdata_i = q0[0].wdata; m0_we_i = q0[0].we;
            end else begin
                m0_req_i = 0;
            end
        end
    end

    initial begin
        m1_req_i = 0; m1_addr_i = '0; m1_wdata_i = '0; m1_we_i = 0;
        forever begin
            @(negedge clk);
            if (m1_req_i && m1_ready_o && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                m1_req_i = 1; m1_addr_i = q1[0].addr; m1_wdata_i = q1[0].wdata; m1_we_i = q1[0].we;
            end else begin
                m1_req_i = 0;
            end
        end
    end

    // ---------------- slave ----------------
    int          ack_delay = 0;     // wait states before ack; -1 = never ack
    logic [31:0] slave_data = '0;
    bit          stray_ack = 0;

    initial begin
        int beat;
        beat = 0;
        forever begin
            @(posedge clk);
            #2;
            if (cyc_o && stb_o) begin
                ack_i = (ack_delay >= 0 && beat == ack_delay);
                beat++;
            end else begin
                ack_i = stray_ack;
                beat = 0;
            end
            data_i = slave_data;
        end
    end

    // ---------------- monitor ----------------
    typedef struct { bit who; int cyc; bit err; logic [31:0] rdata; } ev_t;
    ev_t         evq[$];
    int          run = 0, last_len = 0, n_runs = 0;
    bit          run_stable = 1, last_stable = 1, last_we = 0;
    logic [1:0]  last_sel = '0;
    logic [31:0] first_addr = '0, first_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (m0_ready_o) evq.push_back('{1'b0, cyc_n, m0_err_o, m0_rdata_o});
            if (m1_ready_o) evq.push_back('{1'b1, cyc_n, m1_err_o, m1_rdata_o});
            if (stb_o) begin
                if (run == 0) begin
                    first_addr = addr_o; first_data = data_o; run_stable = 1;
                end else if (addr_o !== first_addr || data_o !== first_data) begin
                    run_stable = 0;
                end
                run++;
                last_sel = sel_o;
                last_we = we_o;
            end else if (run != 0) begin
                last_len = run; last_stable = run_stable; n_runs++; run = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_ni = 0;
        q0.delete(); q1.delete();
        stray_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1;
        evq.delete();
        n_runs = 0;
    endtask

    task automatic wait_events(input int n, input int budget);
        int t;
        t = 0;
        while (evq.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("event_count", 32'(evq.size()), 32'(n));
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic [31:0] d, input logic w);
        txn_t t;
        t.addr = a; t.wdata = d; t.we = w;
        return t;
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cyc", 32'(cyc_o), 32'h0);
        chk("reset_addr", addr_o, 32'h0);
        chk("reset_ready", 32'({m0_ready_o, m1_ready_o}), 32'h0);
        chk("reset_rdata", m0_rdata_o, 32'h0);
        rst_ni = 1;
        repeat (2) @(posedge clk);
        #1;

        // Single read from m0
        ack_delay = 0; slave_data = 32'hCAFE_0001;
        q0.push_back(mk(32'h1000_0004, 32'h0, 1'b0));
        wait_events(1, 20);
        if (evq.size() >= 1) begin
            chk("read_who", 32'(evq[0].who), 32'h0);
            chk("read_latency", 32'(evq[0].cyc - raise0), 32'd2);
            chk("read_rdata", evq[0].rdata, 32'hCAFE_0001);
            chk("read_err", 32'(evq[0].err), 32'h0);
        end
        chk("read_sel", 32'(last_sel), 32'h1);
        chk("read_stb_len", 32'(last_len), 32'd1);

        // Tie: both request continuously
        do_reset();
        ack_delay = 0; slave_data = 32'h0000_7777;
        q0.push_back(mk(32'h0000_0100, 32'h0, 1'b0));
        q0.push_back(mk(32'h0000_0104, 32'h0, 1'b0));
        q1.push_back(mk(32'h1000_0200, 32'h0, 1'b0));
        q1.push_back(mk(32'h1000_0204, 32'h0, 1'b0));
        wait_events(4, 60);
        if (evq.size() >= 4) begin
            chk("tie_who0", 32'(evq[0].who), 32'h0);
            chk("tie_who1", 32'(evq[1].who), 32'h1);
            chk("tie_who2", 32'(evq[2].who), 32'h0);
            chk("tie_who3", 32'(evq[3].who), 32'h1);
            chk("tie_gap1", 32'(evq[1].cyc - evq[0].cyc), 32'd3);
            chk("tie_gap2", 32'(evq[2].cyc - evq[1].cyc), 32'd3);
            chk("tie_gap3", 32'(evq[3].cyc - evq[2].cyc), 32'd3);
        end

        // Wait states on an m1 write; preceding read sets rdata
        do_reset();
        ack_delay = 0; slave_data = 32'h1234_5678;
        q0.push_back(mk(32'h0000_0040, 32'h0, 1'b0));
        wait_events(1, 20);
        ack_delay = 5; slave_data = 32'hFFFF_0000;
        q1.push_back(mk(32'h2000_0000, 32'h55AA_55AA, 1'b1));
        wait_events(2, 40);
        if (evq.size() >= 2) begin
            chk("write_who", 32'(evq[1].who), 32'h1);
            chk("write_err", 32'(evq[1].err), 32'h0);
            chk("write_rdata_kept", evq[1].rdata, 32'h1234_5678);
        end
        chk("write_stb_len", 32'(last_len), 32'd6);
        chk("write_we", 32'(last_we), 32'h1);
        chk("write_sel", 32'(last_sel), 32'h2);
        chk("write_stable", 32'(last_stable), 32'h1);

        // Timeout on an m0 read after a successful m1 read
        do_reset();
        ack_delay = 0; slave_data = 32'hDEAD_BEEF;
        q1.push_back(mk(32'h0000_0080, 32'h0, 1'b0));
        wait_events(1, 20);
        ack_delay = -1;
        q0.push_back(mk(32'h3000_0010, 32'h0, 1'b0));
        wait_events(2, 60);
        if (evq.size() >= 2) begin
            chk("prev_rdata", evq[0].rdata, 32'hDEAD_BEEF);
            chk("tmo_who", 32'(evq[1].who), 32'h0);
            chk("tmo_err", 32'(evq[1].err), 32'h1);
            chk("tmo_rdata", evq[1].rdata, 32'h0);
        end
        chk("tmo_stb_len", 32'(last_len), 32'd15);
        chk("tmo_sel", 32'(last_sel), 32'h3);
        chk("tmo_idle", 32'(cyc_o), 32'h0);

        // Reset during the second bus cycle of a waiting transfer
        do_reset();
        ack_delay = -1;
        q0.push_back(mk(32'h1000_0020, 32'h0, 1'b0));
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 2; i++) begin
            @(posedge clk);
            #1;
            if (stb_o) cnt++;
        end
        chk("bus_cycle2_reached", 32'(cnt), 32'd2);
        #2;
        rst_ni = 0;
        #1;
        chk("async_cyc", 32'(cyc_o), 32'h0);
        chk("async_stb", 32'(stb_o), 32'h0);
        q0.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_ready", 32'(evq.size()), 32'h0);
        rst_ni = 1;
        ack_delay = 0; slave_data = 32'h0BAD_F00D;
        q1.push_back(mk(32'h2000_0008, 32'h0, 1'b0));
        wait_events(1, 20);
        if (evq.size() >= 1) begin
            chk("after_rst_who", 32'(evq[0].who), 32'h1);
            chk("after_rst_rdata", evq[0].rdata, 32'h0BAD_F00D);
            chk("after_rst_err", 32'(evq[0].err), 32'h0);
        end

        // Stray ack while idle
        do_reset();
        slave_data = 32'h5555_AAAA;
        stray_ack = 1;
        @(posedge clk);
        #1;
        stray_ack = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_no_ready", 32'(evq.size()), 32'h0);
        chk("stray_no_bus", 32'(n_runs), 32'h0);
        chk("stray_rdata", m0_rdata_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning the number of bus cycles to wait for ack_i before aborting a transfer.
REQ-002 Parameter SEL_LSB, default 28, meaning the lowest address bit of the 2-bit slave select field.
REQ-003 Port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Ports m0_req_i / m1_req_i, input, 1 bit each: requester 0 (core data port) and requester 1 (DMA) transfer request; each is held high until that requester's ready pulse.
REQ-006 Ports m0_addr_i / m1_addr_i and m0_wdata_i / m1_wdata_i, input, 32 bits each: address and write data, stable while req is high.
REQ-007 Ports m0_we_i / m1_we_i, input, 1 bit each: 1 = write, 0 = read.
REQ-008 Ports m0_ready_o / m1_ready_o, output, 1 bit each: one-cycle completion pulse.
REQ-009 Ports m0_err_o / m1_err_o, output, 1 bit each: asserted with ready when the transfer timed out.
REQ-010 Ports m0_rdata_o / m1_rdata_o, output, 32 bits each: read data, valid only in the ready cycle.
REQ-011 Ports cyc_o, stb_o, we_o, output, 1 bit each: Wishbone bus-master control signals.
REQ-012 Ports addr_o and data_o, output, 32 bits each: bus address and write data.
REQ-013 Port sel_o, output, 2 bits: slave select, equal to addr_o[SEL_LSB+1:SEL_LSB].
REQ-014 Ports data_i, input, 32 bits, and ack_i, input, 1 bit: slave read data and acknowledge.

Function
REQ-015 FSM states SHALL be IDLE, BUS, DONE; state, grant, and the timeout counter are registered.
REQ-016 IDLE: if any request is high, the block SHALL latch the winner into grant, latch the winner's addr/wdata/we into bus registers, and go to BUS on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin:
- a single request wins;
- with both requests high, the requester not granted last wins;
- last_grant resets to 1, so m0 wins the first tie.
REQ-018 BUS: cyc_o=1 and stb_o=1, with we_o/addr_o/data_o/sel_o driven from the latched registers and held constant.
REQ-019 BUS with ack_i=1 at a rising edge: the block SHALL capture data_i into the rdata register, set err=0, go to DONE, and clear the counter.
REQ-020 BUS with ack_i=0: the counter SHALL increment each cycle. When the counter equals TIMEOUT-1 without ack, the block SHALL go to DONE with err=1 and rdata=32'h0000_0000.
REQ-021 DONE, exactly one cycle:
- cyc_o=0 and stb_o=0;
- mX_ready_o=1 for the granted requester only;
- mX_err_o follows the err register;
- last_grant is updated;
- next state is IDLE.
REQ-022 Latency without bus wait states: request seen in IDLE at edge k → cyc/stb high in cycle k+1; ack at edge k+1 → ready in cycle k+2. Minimum three cycles per transfer and one idle cycle between transfers.
REQ-023 Requests that arrive or change during BUS/DONE SHALL be ignored until the next IDLE evaluation. A requester whose req drops mid-transfer still receives its ready pulse.
REQ-024 ack_i arriving in IDLE or DONE SHALL be ignored.
REQ-025 The non-granted requester's ready_o/err_o SHALL be 0 in all cycles. rdata_o for both requesters SHALL be driven from the shared rdata register.
REQ-026 Write transfers SHALL return ready with rdata unchanged from the previous value.

Reset
REQ-027 While rst_ni=0, the following SHALL hold, asynchronously:
- state=IDLE, counter=0, last_grant=1, err=0;
- cyc_o=0, stb_o=0, we_o=0;
- addr_o=0, data_o=0, sel_o=0;
- all ready/err outputs=0, rdata=0.
REQ-028 Reset asserted mid-transfer SHALL abort immediately with no ready pulse. After release, arbitration SHALL restart from IDLE.

Verification
REQ-029 Single read: m0 read at addr 32'h1000_0004, ack_i=1 with data_i=32'hCAFE_0001 on the first BUS cycle → sel_o=2'b01, m0_ready_o pulse 2 cycles after req, m0_rdata_o=32'hCAFE_0001, err=0.
REQ-030 Tie: m0 and m1 both request continuously, ack always immediate → grants alternate m0, m1, m0, m1; each ready 3 cycles apart.
REQ-031 Wait states: m1 write of 32'h55AA_55AA to 32'h2000_0000, ack_i delayed 5 cycles → stb_o high for 6 cycles, we_o=1, data_o stable throughout, one m1_ready_o pulse.
REQ-032 Timeout: m0 read, ack_i never asserted → stb_o high for exactly 15 cycles, then m0_ready_o=1, m0_err_o=1, m0_rdata_o=0, bus returns to idle.
REQ-033 Reset mid-BUS: rst_ni low during cycle 2 of a waiting transfer → cyc_o/stb_o drop without a clock edge, no ready pulse; after release, m1 request is served normally.
REQ-034 Stray ack: ack_i pulse while IDLE → no ready pulse, state stays IDLE.
